// File: rtl/i2c_types_pkg.sv
// Shared types for the I2C slave responder.
// Holds the FSM state encoding, the bit-counter width and a helper that maps
// the transmit bit counter to the byte bit driven onto SDA (MSB first).
package i2c_types_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

  localparam int BYTE_W    = 8;
  // Receive path counts sampled bits 0..8, so one bit more than a byte index.
  localparam int BIT_CNT_W = 4;

  // Bit index of the byte to drive while transmitting bit number cnt (0 = MSB).
  function automatic logic [2:0] tx_bit_idx(input logic [BIT_CNT_W-1:0] cnt);
    return 3'(4'd7 - cnt);
  endfunction

endpackage

// File: rtl/i2c_slave_line_sync.sv
// Bus line conditioning for the I2C slave.
// Brings the asynchronous SCL/SDA lines into the clk domain with 2-flop
// synchronizers (reset to 1 = idle bus), keeps one extra registered copy of
// each synchronized line and derives SCL edges and START/STOP conditions.
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   scl, sda        raw bus lines
//   sda_s           synchronized SDA level
//   scl_rise        one-cycle pulse on synchronized SCL 0->1
//   scl_fall        one-cycle pulse on synchronized SCL 1->0
//   start           SDA 1->0 while SCL high
//   stop            SDA 0->1 while SCL high
module i2c_slave_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_meta;
  logic [1:0] sda_meta;
  logic       scl_prev;
  logic       sda_prev;
  logic       scl_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta <= 2'b11;
      sda_meta <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_meta <= {scl_meta[0], scl};
      sda_meta <= {sda_meta[0], sda};
      scl_prev <= scl_meta[1];
      sda_prev <= sda_meta[1];
    end
  end

  assign scl_s    = scl_meta[1];
  assign sda_s    = sda_meta[1];
  assign scl_rise = !scl_prev && scl_s;
  assign scl_fall = scl_prev && !scl_s;
  // SCL must be high on both samples so an SDA change racing an SCL edge is
  // not mistaken for a bus condition.
  assign start    = scl_prev && scl_s && sda_prev && !sda_s;
  assign stop     = scl_prev && scl_s && !sda_prev && sda_s;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C slave with a small byte-addressed memory.
// Answers SLAVE_ADDR. The first write byte after the address sets the memory
// pointer; further write bytes are stored at the pointer, reads return
// mem[pointer]; the pointer auto-increments and wraps at MEM_DEPTH.
// Optional clock stretching: define I2C_SLAVE_CLOCK_STRETCH_EN to hold SCL low
// for STRETCH_CYCLES clk_i after each ACK bit while addressed.
// Ports:
//   clk_i, rst_n_i  system clock (>= 8x SCL), asynchronous active-low reset
//   scl_i, sda_i    asynchronous bus lines
//   sda_oe_o        1 = pull SDA low
//   scl_oe_o        1 = pull SCL low (stretch build only, else 0)
//   start_o/stop_o  one-cycle pulse per START (incl. repeated) / STOP
//   byte_valid_o    one-cycle pulse per byte completed at this slave
//   byte_o, rw_o    byte and direction (1 = read), valid with byte_valid_o
//   busy_o          high from addressed ACK until STOP, START or NACK
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR     = 7'h22,
  parameter int         MEM_DEPTH      = 32,
  parameter int         STRETCH_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       scl_oe_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       rw_o,
  output logic       busy_o
);
  import i2c_types_pkg::*;

  localparam int PTR_W = $clog2(MEM_DEPTH);

  if (MEM_DEPTH < 2 || MEM_DEPTH > 256 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0 ||
      STRETCH_CYCLES < 1) begin : g_bad_params
    $error("i2c_slave_responder: illegal MEM_DEPTH or STRETCH_CYCLES");
  end

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_slave_line_sync u_line_sync (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .scl      (scl_i),
    .sda      (sda_i),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start_det),
    .stop     (stop_det)
  );

  state_t                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]      shift_q, shift_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   busy_q, busy_d;
  logic                   rw_q, rw_d;
  logic [BYTE_W-1:0]      byte_q, byte_d;
  logic                   byte_valid_d;
  logic                   mem_we;
  logic [BYTE_W-1:0]      mem [MEM_DEPTH];

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    ptr_d        = ptr_q;
    sda_oe_d     = sda_oe_q;
    busy_d       = busy_q;
    rw_d         = rw_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    mem_we       = 1'b0;

    // Bus conditions win over any SCL edge seen in the same cycle.
    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE, IGNORE: sda_oe_d = 1'b0;

        ADDR, PTR, WR_DATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[BYTE_W-2:0], sda_s};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end else if (scl_fall && bit_cnt_q == BIT_CNT_W'(8)) begin
            bit_cnt_d = '0;
            if (state_q == ADDR) begin
              if (shift_q[7:1] == SLAVE_ADDR) begin
                state_d  = ADDR_ACK;
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                rw_d     = shift_q[0];
              end else begin
                state_d  = IGNORE;
              end
            end else if (state_q == PTR) begin
              ptr_d    = shift_q[PTR_W-1:0];
              state_d  = WR_ACK;
              sda_oe_d = 1'b1;
            end else begin
              mem_we       = 1'b1;
              byte_d       = shift_q;
              byte_valid_d = 1'b1;
              ptr_d        = ptr_q + PTR_W'(1);
              state_d      = WR_ACK;
              sda_oe_d     = 1'b1;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (rw_q) begin
              state_d  = RD_DATA;
              shift_d  = mem[ptr_q];
              sda_oe_d = ~mem[ptr_q][7];
            end else begin
              state_d  = PTR;
              sda_oe_d = 1'b0;
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            state_d   = WR_DATA;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
          end
        end

        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == BIT_CNT_W'(7)) begin
              state_d      = RD_ACK;
              bit_cnt_d    = '0;
              sda_oe_d     = 1'b0;
              byte_d       = shift_q;
              byte_valid_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
              sda_oe_d  = ~shift_q[tx_bit_idx(bit_cnt_q + BIT_CNT_W'(1))];
            end
          end
        end

        RD_ACK: begin
          // Master's ACK/NACK is decided on the rising edge; the next byte is
          // only put on the bus once SCL falls again.
          if (scl_rise) begin
            if (sda_s) begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end else begin
              ptr_d = ptr_q + PTR_W'(1);
            end
          end else if (scl_fall) begin
            state_d   = RD_DATA;
            bit_cnt_d = '0;
            shift_d   = mem[ptr_q];
            sda_oe_d  = ~mem[ptr_q][7];
          end
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      ptr_q        <= '0;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      rw_q         <= 1'b0;
      byte_q       <= '0;
      byte_valid_o <= 1'b0;
      start_o      <= 1'b0;
      stop_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      ptr_q        <= ptr_d;
      sda_oe_q     <= sda_oe_d;
      busy_q       <= busy_d;
      rw_q         <= rw_d;
      byte_q       <= byte_d;
      byte_valid_o <= byte_valid_d;
      start_o      <= start_det;
      stop_o       <= stop_det;
    end
  end

  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[ptr_q] <= shift_q;
    end
  end

`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
  localparam int STRETCH_W = $clog2(STRETCH_CYCLES + 1);

  logic                 stretch_go;
  logic [STRETCH_W-1:0] stretch_cnt_q;

  // Every SCL fall in an ACK state ends an ACK bit of this slave.
  assign stretch_go = scl_fall && !start_det && !stop_det &&
                      (state_q == ADDR_ACK || state_q == WR_ACK || state_q == RD_ACK);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stretch_cnt_q <= '0;
    end else if (stretch_go) begin
      stretch_cnt_q <= STRETCH_W'(STRETCH_CYCLES);
    end else if (stretch_cnt_q != '0) begin
      stretch_cnt_q <= stretch_cnt_q - STRETCH_W'(1);
    end
  end

  assign scl_oe_o = (stretch_cnt_q != '0);
`else
  assign scl_oe_o = 1'b0;
`endif

  assign sda_oe_o = sda_oe_q;
  assign busy_o   = busy_q;
  assign rw_o     = rw_q;
  assign byte_o   = byte_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: a bit-banged I2C master drives an
// open-drain bus model; expected byte_valid_o events are queued as stimulus is
// issued and a monitor process pops and compares them when the DUT reports.
`timescale 1ns/1ps
module tb_i2c_slave_responder;
  import i2c_types_pkg::*;

  localparam int STRETCH = 16;
  localparam int Q       = 100;  // quarter SCL period = 10 clk cycles

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe, scl_oe, start_p, stop_p, bv, rw, busy;
  logic [7:0] byte_out;
  logic       scl_line, sda_line;

  assign scl_line = scl_m & ~scl_oe;
  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_responder #(
    .SLAVE_ADDR     (7'h22),
    .MEM_DEPTH      (32),
    .STRETCH_CYCLES (STRETCH)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .scl_i        (scl_line),
    .sda_i        (sda_line),
    .sda_oe_o     (sda_oe),
    .scl_oe_o     (scl_oe),
    .start_o      (start_p),
    .stop_o       (stop_p),
    .byte_valid_o (bv),
    .byte_o       (byte_out),
    .rw_o         (rw),
    .busy_o       (busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       rw;
  } exp_t;

  exp_t exp_q[$];
  exp_t popped;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_starts = 0, exp_stops = 0, got_starts = 0, got_stops = 0;
  int   stretch_run = 0, stretch_pulses = 0, scl_oe_seen = 0;

  task automatic chk1(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, act, req);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic r);
    exp_t e;
    e.data = d;
    e.rw   = r;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor and bus-condition / stretch observers.
  always @(negedge clk) begin
    if (!rst_n) begin
      stretch_run = 0;
    end else begin
      if (start_p) got_starts++;
      if (stop_p)  got_stops++;
      if (bv) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte_valid: byte_o=0x%02h rw_o=%0b, expected no output",
                   byte_out, rw);
        end else begin
          popped = exp_q.pop_front();
          chk8("byte_o", byte_out, popped.data);
          chk1("rw_o", rw, popped.rw);
        end
      end
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
      if (scl_oe) begin
        stretch_run++;
      end else if (stretch_run != 0) begin
        chk_int("scl_oe_stretch_len", stretch_run, STRETCH);
        stretch_pulses++;
        stretch_run = 0;
      end
`else
      if (scl_oe) scl_oe_seen++;
`endif
    end
  end

  // Bus-level master; line values are computed from the drivers directly so
  // they are valid in the same timestep.
  task automatic wait_scl_high();
    int n = 0;
    while ((scl_m & ~scl_oe) !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if ((scl_m & ~scl_oe) !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL scl_release_timeout: SCL low after %0d cycles, expected released", n);
    end
  endtask

  task automatic clk_bit(input logic b, output logic r);
    sda_m = b;
    #Q;
    scl_m = 1'b1;
    wait_scl_high();
    #Q;
    r = sda_m & ~sda_oe;
    #Q;
    scl_m = 1'b0;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      d[i] = r;
    end
    clk_bit(nack, r);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    #Q;
    scl_m = 1'b1;
    wait_scl_high();
    #Q;
    sda_m = 1'b0;
    exp_starts++;
    #Q;
    scl_m = 1'b0;
    #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    #Q;
    scl_m = 1'b1;
    wait_scl_high();
    #Q;
    sda_m = 1'b1;
    exp_stops++;
    #Q;
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic       ack;
    logic [7:0] d;

    // Reset state
    repeat (3) @(negedge clk);
    chk1("rst_sda_oe", sda_oe, 1'b0);
    chk1("rst_scl_oe", scl_oe, 1'b0);
    chk1("rst_start", start_p, 1'b0);
    chk1("rst_stop", stop_p, 1'b0);
    chk1("rst_byte_valid", bv, 1'b0);
    chk8("rst_byte", byte_out, 8'h00);
    chk1("rst_rw", rw, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_int("rst_state", int'(dut.state_q), int'(IDLE));

    // Write 0x44, ptr 0x03, data 0xA5 0x5A, STOP
    bus_start();
    send_byte(8'h44, ack); chk1("t1_addr_ack", ack, 1'b0);
    chk1("t1_busy", busy, 1'b1);
    send_byte(8'h03, ack); chk1("t1_ptr_ack", ack, 1'b0);
    push_exp(8'hA5, 1'b0);
    send_byte(8'hA5, ack); chk1("t1_d0_ack", ack, 1'b0);
    push_exp(8'h5A, 1'b0);
    send_byte(8'h5A, ack); chk1("t1_d1_ack", ack, 1'b0);
    bus_stop();
    chk1("t1_busy_after_stop", busy, 1'b0);

    // Set ptr 0x03, repeated START, read two bytes, NACK the last
    bus_start();
    send_byte(8'h44, ack); chk1("t2_addr_ack", ack, 1'b0);
    send_byte(8'h03, ack); chk1("t2_ptr_ack", ack, 1'b0);
    bus_start();
    send_byte(8'h45, ack); chk1("t2_rd_addr_ack", ack, 1'b0);
    push_exp(8'hA5, 1'b1);
    recv_byte(1'b0, d); chk8("t2_rd0", d, 8'hA5);
    chk1("t2_busy_mid_read", busy, 1'b1);
    push_exp(8'h5A, 1'b1);
    recv_byte(1'b1, d); chk8("t2_rd1", d, 8'h5A);
    chk1("t2_busy_after_nack", busy, 1'b0);
    chk1("t2_sda_released", sda_oe, 1'b0);
    bus_stop();

    // Pointer survives STOP (NACKed byte at 4 does not advance it)
    bus_start();
    send_byte(8'h45, ack); chk1("t2b_addr_ack", ack, 1'b0);
    push_exp(8'h5A, 1'b1);
    recv_byte(1'b1, d); chk8("t2b_rd_keep_ptr", d, 8'h5A);
    bus_stop();

    // Foreign address 0x50: no ACK, nothing reported, not busy
    bus_start();
    send_byte(8'h50, ack); chk1("t3_addr_nack", ack, 1'b1);
    chk1("t3_busy", busy, 1'b0);
    send_byte(8'h99, ack); chk1("t3_data_nack", ack, 1'b1);
    chk1("t3_busy_data", busy, 1'b0);
    bus_stop();

    // Pointer wrap: ptr 0x1F, write 0x11 0x22, read back across the wrap
    bus_start();
    send_byte(8'h44, ack); chk1("t4_addr_ack", ack, 1'b0);
    send_byte(8'h1F, ack); chk1("t4_ptr_ack", ack, 1'b0);
    push_exp(8'h11, 1'b0);
    send_byte(8'h11, ack); chk1("t4_d0_ack", ack, 1'b0);
    push_exp(8'h22, 1'b0);
    send_byte(8'h22, ack); chk1("t4_d1_ack", ack, 1'b0);
    bus_stop();
    bus_start();
    send_byte(8'h44, ack); chk1("t4_addr2_ack", ack, 1'b0);
    send_byte(8'h1F, ack); chk1("t4_ptr2_ack", ack, 1'b0);
    bus_start();
    send_byte(8'h45, ack); chk1("t4_rd_addr_ack", ack, 1'b0);
    push_exp(8'h11, 1'b1);
    recv_byte(1'b0, d); chk8("t4_mem31", d, 8'h11);
    push_exp(8'h22, 1'b1);
    recv_byte(1'b1, d); chk8("t4_mem0", d, 8'h22);
    bus_stop();

    // Reset mid-read while the slave holds SDA low (mem[4] = 0x5A, MSB 0)
    bus_start();
    send_byte(8'h44, ack); chk1("t5_addr_ack", ack, 1'b0);
    send_byte(8'h04, ack); chk1("t5_ptr_ack", ack, 1'b0);
    bus_start();
    send_byte(8'h45, ack); chk1("t5_rd_addr_ack", ack, 1'b0);
    sda_m = 1'b1;
    #Q;
    scl_m = 1'b1;
    wait_scl_high();
    #Q;
    chk1("t5_sda_driven_low", sda_m & ~sda_oe, 1'b0);
    chk1("t5_sda_oe_before_rst", sda_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("t5_sda_oe_at_rst", sda_oe, 1'b0);
    chk1("t5_sda_line_at_rst", sda_line, 1'b1);
    chk1("t5_scl_oe_at_rst", scl_oe, 1'b0);
    chk1("t5_busy_at_rst", busy, 1'b0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_int("t5_state_after_rst", int'(dut.state_q), int'(IDLE));
    chk1("t5_sda_oe_after_rst", sda_oe, 1'b0);

    // Pointer cleared by reset, memory kept: read returns mem[0] = 0x22
    bus_start();
    send_byte(8'h45, ack); chk1("t6_addr_ack", ack, 1'b0);
    push_exp(8'h22, 1'b1);
    recv_byte(1'b1, d); chk8("t6_ptr0_after_rst", d, 8'h22);
    bus_stop();

    repeat (20) @(negedge clk);
    chk_int("scoreboard_drained", exp_q.size(), 0);
    chk_int("start_pulses", got_starts, exp_starts);
    chk_int("stop_pulses", got_stops, exp_stops);
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
    chk1("stretch_pulses_seen", stretch_pulses > 0, 1'b1);
`else
    chk_int("scl_oe_never_high", scl_oe_seen, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
